// File: rtl/uart_feeder_pkg.sv
// Shared types and UART register map for the Tx feeder.
package uart_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        POLL_RD,
        POLL_WAIT
    } FeederState;

    localparam logic [2:0]  UART_ADDR_CTRL     = 3'b000;
    localparam logic [2:0]  UART_ADDR_TXBUF    = 3'b010;
    localparam int unsigned UART_CTRL_BUSY_BIT = 1;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers and a registered head output (dout).
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] rd_ptr_next;
    logic        push_ok;
    logic        pop_ok;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok      = pop && !empty;
    assign push_ok     = push && (!full || pop_ok);
    assign rd_ptr_next = rd_ptr + {{AW{1'b0}}, pop_ok};

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // dout tracks the head the next cycle will see; a write landing on that
    // slot this cycle is forwarded so a push into an empty FIFO is usable at once.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0])) begin
                dout <= din;
            end else begin
                dout <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Streams buffered bytes into UART_Component's Tx buffer and polls its busy bit.
// Optional poll timeout with sticky err: define UART_TX_FEEDER_TIMEOUT_EN.
module uart_tx_feeder
    import uart_feeder_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned POLL_GAP = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       uart_cs_n,
    output logic       uart_rd_n,
    output logic       uart_wr_n,
    output logic [2:0] uart_addr,
    output logic [7:0] uart_wdata,
    input  logic [7:0] uart_rdata,
    output logic       busy,
    output logic       err
);

    localparam logic [3:0] GAP_LOAD = 4'(POLL_GAP - 1);

    FeederState state;
    logic [3:0] gap_cnt;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       uart_busy;
    logic       timeout_hit;
    logic       unused_rdata;

    assign s_ready      = !fifo_full;
    assign push         = s_valid && s_ready;
    assign pop          = (state == IDLE) && !fifo_empty;
    assign busy         = (state != IDLE) || !fifo_empty;
    assign uart_busy    = uart_rdata[UART_CTRL_BUSY_BIT];
    assign unused_rdata = ^{uart_rdata[7:2], uart_rdata[0]};

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign timeout_hit = ((state == POLL_RD) || (state == POLL_WAIT)) && (to_cnt == 16'hFFFF);

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (pop) begin
                to_cnt <= '0;
            end else if ((state == POLL_RD) || (state == POLL_WAIT)) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Outputs are registered alongside the state, so each arm drives the
    // strobe levels that belong to the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            uart_cs_n  <= 1'b1;
            uart_rd_n  <= 1'b1;
            uart_wr_n  <= 1'b1;
            uart_addr  <= UART_ADDR_CTRL;
            uart_wdata <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        uart_wdata <= fifo_dout;
                        uart_addr  <= UART_ADDR_TXBUF;
                        uart_cs_n  <= 1'b0;
                        state      <= WR_SETUP;
                    end
                end
                WR_SETUP: begin
                    uart_wr_n <= 1'b0;
                    state     <= WR_STROBE;
                end
                WR_STROBE: begin
                    uart_wr_n <= 1'b1;
                    uart_addr <= UART_ADDR_CTRL;
                    state     <= WR_HOLD;
                end
                WR_HOLD: begin
                    uart_rd_n <= 1'b0;
                    state     <= POLL_RD;
                end
                POLL_RD: begin
                    uart_rd_n <= 1'b1;
                    if (timeout_hit || !uart_busy) begin
                        uart_cs_n <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= POLL_WAIT;
                    end
                end
                POLL_WAIT: begin
                    if (timeout_hit) begin
                        uart_cs_n <= 1'b1;
                        state     <= IDLE;
                    end else if (gap_cnt == 4'd0) begin
                        uart_rd_n <= 1'b0;
                        state     <= POLL_RD;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    uart_cs_n <= 1'b1;
                    uart_rd_n <= 1'b1;
                    uart_wr_n <= 1'b1;
                    uart_addr <= UART_ADDR_CTRL;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural UART busy-bit model.
module tb_uart_tx_feeder;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       uart_cs_n;
    logic       uart_rd_n;
    logic       uart_wr_n;
    logic [2:0] uart_addr;
    logic [7:0] uart_wdata;
    logic [7:0] uart_rdata;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;

    // UART model: busy for the first busy_polls reads after poll_base, or always when stuck.
    int          polls_total = 0;
    int          poll_base   = 0;
    int          busy_polls  = 0;
    logic        stuck       = 1'b0;
    logic [10:0] wr_log[$];

    assign uart_rdata = {6'b0, (stuck || ((polls_total - poll_base) <= busy_polls)), 1'b0};

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!uart_cs_n && !uart_rd_n) polls_total = polls_total + 1;
        if (!uart_cs_n && !uart_wr_n) wr_log.push_back({uart_addr, uart_wdata});
    end

    uart_tx_feeder #(
        .DEPTH    (4),
        .POLL_GAP (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .uart_cs_n  (uart_cs_n),
        .uart_rd_n  (uart_rd_n),
        .uart_wr_n  (uart_wr_n),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata),
        .busy       (busy),
        .err        (err)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [7:0] b);
        s_data  = b;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        repeat (3) tick();
        checks++; if ({uart_cs_n, uart_rd_n, uart_wr_n} !== 3'b111) begin failures++; $display("FAIL reset_strobes got %b expected 111", {uart_cs_n, uart_rd_n, uart_wr_n}); end
        checks++; if (uart_addr !== 3'd0) begin failures++; $display("FAIL reset_addr got %0d expected 0", uart_addr); end
        checks++; if (uart_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got %h expected 00", uart_wdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b expected 0", err); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got %b expected 1", s_ready); end
        s_valid = 1'b0;
        reset   = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_valid_ignored busy got %b expected 0", busy); end
        checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL reset_no_writes got %0d expected 0", wr_log.size()); end
    endtask

    task automatic test_single;
        logic [7:0] wr_pat, rd_pat, busy_pat;
        logic [2:0] addr_w;
        logic [7:0] data_w;
        int start;
        start      = wr_log.size();
        busy_polls = 0;
        poll_base  = polls_total;
        addr_w     = '0;
        data_w     = '0;
        push_one(8'h4F);
        for (int k = 1; k <= 8; k++) begin
            tick();
            wr_pat[k-1]   = uart_wr_n;
            rd_pat[k-1]   = uart_rd_n;
            busy_pat[k-1] = busy;
            if (k == 2) begin addr_w = uart_addr; data_w = uart_wdata; end
        end
        checks++; if (wr_pat !== 8'b1111_1101) begin failures++; $display("FAIL single_wr_n got %b expected 11111101", wr_pat); end
        checks++; if (addr_w !== 3'd2) begin failures++; $display("FAIL single_wr_addr got %0d expected 2", addr_w); end
        checks++; if (data_w !== 8'h4F) begin failures++; $display("FAIL single_wr_data got %h expected 4f", data_w); end
        checks++; if (rd_pat !== 8'b1111_0111) begin failures++; $display("FAIL single_rd_n got %b expected 11110111", rd_pat); end
        checks++; if (busy_pat !== 8'b0000_1111) begin failures++; $display("FAIL single_busy got %b expected 00001111", busy_pat); end
        checks++;
        if (wr_log.size() != start + 1) begin failures++; $display("FAIL single_log_size got %0d expected %0d", wr_log.size(), start + 1); end
        else if (wr_log[start] !== {3'd2, 8'h4F}) begin failures++; $display("FAIL single_log got %h expected %h", wr_log[start], {3'd2, 8'h4F}); end
    endtask

    task automatic test_busy_poll;
        logic [11:0] rd_pat, cs_pat;
        int bad_wdata;
        bad_wdata  = 0;
        busy_polls = 3;
        poll_base  = polls_total;
        push_one(8'h41);
        for (int k = 1; k <= 12; k++) begin
            tick();
            rd_pat[k-1] = uart_rd_n;
            cs_pat[k-1] = uart_cs_n;
            if (!uart_cs_n && uart_wdata !== 8'h41) bad_wdata++;
        end
        checks++; if (rd_pat !== 12'hD57) begin failures++; $display("FAIL poll_rd_n got %h expected d57", rd_pat); end
        checks++; if (cs_pat !== 12'hC00) begin failures++; $display("FAIL poll_cs_n got %h expected c00", cs_pat); end
        checks++; if (bad_wdata != 0) begin failures++; $display("FAIL poll_wdata_stable got %0d bad cycles expected 0", bad_wdata); end
        checks++; if (polls_total - poll_base != 4) begin failures++; $display("FAIL poll_count got %0d expected 4", polls_total - poll_base); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL poll_busy_end got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back;
        int start, waited, cyc;
        logic [7:0] exp_b;
        start = wr_log.size();
        stuck = 1'b1;
        push_one(8'hA0);
        repeat (6) tick();
        for (int i = 1; i <= 4; i++) begin
            checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_before_fill%0d got %b expected 1", i, s_ready); end
            s_data  = 8'hA0 + 8'(i);
            s_valid = 1'b1;
            tick();
        end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got %b expected 0", s_ready); end
        s_data = 8'hA5;
        waited = 0;
        while (!s_ready && waited < 100) begin
            tick();
            waited++;
            if (waited == 5) stuck = 1'b0;
        end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_timeout got %b expected 1", s_ready); end
        checks++; if (waited < 5) begin failures++; $display("FAIL b2b_held got %0d cycles expected >=5", waited); end
        tick();
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL b2b_refill_full got %b expected 0", s_ready); end
        cyc = 0;
        while (busy && cyc < 300) begin tick(); cyc++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain_timeout busy got %b expected 0", busy); end
        checks++;
        if (wr_log.size() != start + 6) begin
            failures++; $display("FAIL b2b_log_size got %0d expected %0d", wr_log.size(), start + 6);
        end else begin
            for (int i = 0; i < 6; i++) begin
                exp_b = 8'hA0 + 8'(i);
                if (wr_log[start+i] !== {3'd2, exp_b}) begin
                    failures++; $display("FAIL b2b_order%0d got %h expected %h", i, wr_log[start+i], {3'd2, exp_b});
                    break;
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int start, p0, n;
        logic found;
        start = wr_log.size();
        stuck = 1'b1;
        p0    = polls_total;
        push_one(8'hB0);
        push_one(8'hB1);
        push_one(8'hB2);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (polls_total > p0 && !uart_cs_n && uart_rd_n && uart_wr_n) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL mid_reach_wait got %b expected 1", found); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL mid_err_before_reset got %b expected 0", err); end
        n = wr_log.size();
        checks++; if (n != start + 1) begin failures++; $display("FAIL mid_first_write got %0d expected %0d", n, start + 1); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({uart_cs_n, uart_rd_n, uart_wr_n} !== 3'b111) begin failures++; $display("FAIL mid_strobes got %b expected 111", {uart_cs_n, uart_rd_n, uart_wr_n}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got %b expected 0", busy); end
        stuck = 1'b0;
        repeat (20) tick();
        checks++; if (wr_log.size() != n) begin failures++; $display("FAIL mid_no_writes got %0d expected %0d", wr_log.size(), n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_after got %b expected 0", busy); end
    endtask

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    task automatic test_timeout;
        int start, cycles, cyc;
        start = wr_log.size();
        stuck = 1'b1;
        push_one(8'hC0);
        push_one(8'hC1);
        cycles = 0;
        while (!err && cycles < 70000) begin tick(); cycles++; end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_err got %b expected 1", err); end
        checks++; if (cycles != 65539) begin failures++; $display("FAIL timeout_cycles got %0d expected 65539", cycles); end
        stuck = 1'b0;
        cyc = 0;
        while (wr_log.size() < start + 2 && cyc < 50) begin tick(); cyc++; end
        checks++;
        if (wr_log.size() != start + 2) begin failures++; $display("FAIL timeout_next_size got %0d expected %0d", wr_log.size(), start + 2); end
        else if (wr_log[start+1] !== {3'd2, 8'hC1}) begin failures++; $display("FAIL timeout_next_byte got %h expected %h", wr_log[start+1], {3'd2, 8'hC1}); end
        repeat (10) tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got %b expected 1", err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL timeout_clear got %b expected 0", err); end
    endtask
`endif

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        test_reset();
        test_single();
        test_busy_poll();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got time %0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
